regmux_rr: RTL and testbench

REGMUX_RR -- requirements
Module: regmux_rr

---
 rtl/regmux_rr_if.sv | 28 ++
 rtl/regmux_rr.sv | 82 ++++++++
 tb/tb_regmux_rr.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/regmux_rr_if.sv
// Handshake bundle for regmux_rr: N input channels with per-channel valid/ready,
// plus one registered output channel carrying data and the source channel index.
interface regmux_rr_if #(
   parameter int WIDTH = 8,
   parameter int N     = 8
);
   localparam int SEL_W = $clog2(N);

   logic                 mode;
   logic [SEL_W-1:0]     sel;
   logic [N*WIDTH-1:0]   in_data;
   logic [N-1:0]         in_valid;
   logic [N-1:0]         in_ready;
   logic [WIDTH-1:0]     out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [SEL_W-1:0]     out_ch;

   modport master (
      output mode, sel, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_ch
   );

   modport slave (
      input  mode, sel, in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_ch
   );
endinterface

// File: rtl/regmux_rr.sv
// N:1 channel mux (direct select or round-robin) into one output register; 1-cycle latency.
// Backpressure: a held item (out_valid && !out_ready) freezes the register and drops all in_ready.
module regmux_rr #(
   parameter int WIDTH = 8,
   parameter int N     = 8
) (
   input  logic     clk,
   input  logic     rst,
   regmux_rr_if.slave bus
);
   localparam int SEL_W = $clog2(N);
   localparam logic [SEL_W:0] NV = (SEL_W+1)'(N);

   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] c;
   logic [SEL_W-1:0] c_rr;
   logic             found;
   logic             found_rr;
   logic             free;
   logic             xfer;
   logic             vld_c;
   logic [WIDTH-1:0] dat_c;
   logic [N-1:0]     rdy;
   logic [SEL_W:0]   t;

   // Search ptr+1, ptr+2, ... with explicit wrap so non-power-of-2 N stays in range.
   always_comb begin
      found_rr = 1'b0;
      c_rr     = '0;
      t        = '0;
      for (int i = 1; i <= N; i++) begin
         t = {1'b0, ptr} + (SEL_W+1)'(i);
         if (t >= NV)
            t = t - NV;
         if (!found_rr && bus.in_valid[t[SEL_W-1:0]]) begin
            found_rr = 1'b1;
            c_rr     = t[SEL_W-1:0];
         end
      end
   end

   always_comb begin
      if (bus.mode) begin
         found = found_rr;
         c     = c_rr;
      end else begin
         found = ({1'b0, bus.sel} < NV);
         c     = bus.sel;
      end
      free  = !bus.out_valid || bus.out_ready;
      rdy   = '0;
      vld_c = 1'b0;
      dat_c = '0;
      for (int k = 0; k < N; k++) begin
         if (found && (c == SEL_W'(k))) begin
            rdy[k] = free;
            vld_c  = bus.in_valid[k];
            dat_c  = bus.in_data[k*WIDTH +: WIDTH];
         end
      end
      xfer = vld_c && free;
   end

   assign bus.in_ready = rst ? '0 : rdy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_ch    <= '0;
         ptr           <= SEL_W'(N-1);
      end else if (free) begin
         bus.out_valid <= xfer;
         if (xfer) begin
            bus.out_data <= dat_c;
            bus.out_ch   <= c;
            if (bus.mode)
               ptr <= c;
         end
      end
   end
endmodule

// File: tb/tb_regmux_rr.sv
// Bench for regmux_rr: N=8 instance tracked by a scan-list reference model,
// plus an N=6 instance for out-of-range select and wrap.
module tb_regmux_rr;
   logic clk;
   logic rst;

   regmux_rr_if #(.WIDTH(8), .N(8)) bus8 ();
   regmux_rr_if #(.WIDTH(8), .N(6)) bus6 ();

   regmux_rr #(.WIDTH(8), .N(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
   regmux_rr #(.WIDTH(8), .N(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [7:0] chdat [8];
   bit         m_valid;
   logic [7:0] m_data;
   int         m_ch;
   int         m_last;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 0;
      m_data  = 8'h00;
      m_ch    = 0;
      m_last  = 7;
   endtask

   task automatic drive_data();
      for (int k = 0; k < 8; k++)
         bus8.in_data[k*8 +: 8] = chdat[k];
   endtask

   // Selection rule: direct index, or the first valid channel after the last grant, wrapping.
   function automatic int pick(input bit md, input int s, input logic [7:0] v, input int last);
      if (!md)
         return (s < 8) ? s : -1;
      for (int k = last + 1; k < 8; k++)
         if (v[k]) return k;
      for (int k = 0; k <= last; k++)
         if (v[k]) return k;
      return -1;
   endfunction

   task automatic cyc();
      int         c;
      bit         free;
      bit         xfer;
      logic [7:0] exp_rdy;
      #1;
      c       = pick(bus8.mode, int'(bus8.sel), bus8.in_valid, m_last);
      free    = !m_valid || bus8.out_ready;
      exp_rdy = (c >= 0 && free) ? 8'(1 << c) : 8'h00;
      check("in_ready", 32'(bus8.in_ready), 32'(exp_rdy));
      xfer = (c >= 0) && free && bus8.in_valid[c];
      @(posedge clk);
      #1;
      if (free) begin
         m_valid = xfer;
         if (xfer) begin
            m_data = chdat[c];
            m_ch   = c;
            if (bus8.mode) m_last = c;
         end
      end
      check("out_valid", 32'(bus8.out_valid), 32'(m_valid));
      check("out_data",  32'(bus8.out_data),  32'(m_data));
      check("out_ch",    32'(bus8.out_ch),    32'(m_ch));
   endtask

   initial begin
      rst            = 1'b1;
      bus8.mode      = 1'b0;
      bus8.sel       = 3'd0;
      bus8.in_valid  = 8'hFF;
      bus8.out_ready = 1'b1;
      bus6.mode      = 1'b0;
      bus6.sel       = 3'd0;
      bus6.in_valid  = 6'h00;
      bus6.out_ready = 1'b1;
      for (int k = 0; k < 8; k++) chdat[k] = 8'hA0 + 8'(k);
      drive_data();
      for (int k = 0; k < 6; k++) bus6.in_data[k*8 +: 8] = 8'hA0 + 8'(k);
      model_reset();

      // reset state, including in_ready forced low despite valid inputs
      #3;
      check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
      check("rst_out_data",  32'(bus8.out_data),  32'd0);
      check("rst_out_ch",    32'(bus8.out_ch),    32'd0);
      check("rst_in_ready",  32'(bus8.in_ready),  32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // direct sweep
      for (int s = 0; s < 8; s++) begin
         bus8.sel = 3'(s);
         cyc();
      end

      // backpressure with sel churn, then release with no bubble
      bus8.sel = 3'd3;
      cyc();
      check("hold_src", 32'(bus8.out_data), 32'hA3);
      bus8.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus8.sel = 3'($urandom_range(0, 7));
         cyc();
      end
      check("held_data", 32'(bus8.out_data), 32'hA3);
      bus8.out_ready = 1'b1;
      bus8.sel       = 3'd6;
      cyc();
      check("release_data", 32'(bus8.out_data), 32'hA6);

      // round-robin, all valid
      bus8.mode = 1'b1;
      for (int i = 0; i < 10; i++) cyc();

      // round-robin, sparse then single
      bus8.in_valid = 8'b0010_0100;
      for (int i = 0; i < 6; i++) cyc();
      bus8.in_valid = 8'b0000_0100;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("single_ch2", 32'(bus8.out_ch), 32'd2);
      end

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         bus8.mode      = 1'($urandom_range(0, 1));
         bus8.sel       = 3'($urandom_range(0, 7));
         bus8.in_valid  = 8'($urandom);
         bus8.out_ready = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < 8; k++) chdat[k] = 8'($urandom);
         drive_data();
         cyc();
      end

      // N=6: out-of-range select, then direct ch5, then round-robin wrap
      bus8.mode      = 1'b0;
      bus8.in_valid  = 8'h00;
      bus8.out_ready = 1'b1;
      bus6.sel       = 3'd7;
      bus6.in_valid  = 6'h3F;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("n6_oor_ready", 32'(bus6.in_ready), 32'd0);
         cyc();
         check("n6_oor_valid", 32'(bus6.out_valid), 32'd0);
      end
      bus6.sel = 3'd5;
      cyc();
      check("n6_sel5_valid", 32'(bus6.out_valid), 32'd1);
      check("n6_sel5_ch",    32'(bus6.out_ch),    32'd5);
      check("n6_sel5_data",  32'(bus6.out_data),  32'hA5);
      bus6.mode = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         check("n6_rr_ch",   32'(bus6.out_ch),   32'(i % 6));
         check("n6_rr_data", 32'(bus6.out_data), 32'hA0 + 32'(i % 6));
      end

      // asynchronous reset while an item is held
      for (int k = 0; k < 8; k++) chdat[k] = 8'hA0 + 8'(k);
      drive_data();
      bus8.in_valid = 8'hFF;
      bus8.sel      = 3'd4;
      cyc();
      bus8.out_ready = 1'b0;
      cyc();
      check("pre_rst_hold", 32'(bus8.out_data), 32'hA4);
      #2;
      rst = 1'b1;
      #1;
      check("arst_out_valid", 32'(bus8.out_valid), 32'd0);
      check("arst_out_data",  32'(bus8.out_data),  32'd0);
      check("arst_in_ready",  32'(bus8.in_ready),  32'd0);
      check("arst_n6_valid",  32'(bus6.out_valid), 32'd0);
      #1;
      rst = 1'b0;
      model_reset();
      bus8.mode      = 1'b1;
      bus8.out_ready = 1'b1;
      cyc();
      check("post_rst_first_ch", 32'(bus8.out_ch),   32'd0);
      check("post_rst_first_dt", 32'(bus8.out_data), 32'hA0);
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
